alu_exec: RTL and testbench

//  Execute-stage ALU: consumes the 5-bit ALU operation code from the decode stage's ALU-control

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_divider.sv | 90 +++++++++
 rtl/alu_exec.sv | 141 ++++++++++++++
 tb/tb_alu_exec.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by decode ALU control), FSM states, default width.
package alu_pkg;
  localparam int XLEN_DEF = 32;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd10;
  localparam logic [4:0] ALU_DIV  = 5'd11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
endpackage

// File: rtl/alu_divider.sv
// Iterative signed restoring divider: XLEN iterations then one sign-fix cycle (done_o).
// Fast cases (x/0, MIN/-1) are flagged combinationally so the caller can skip the iteration.
module alu_divider
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            fast_o,
  output logic [XLEN-1:0] fast_res_o,
  output logic            done_o,
  output logic [XLEN-1:0] quo_o
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            run_q, run_d, fix_q, fix_d, neg_q, neg_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   rem_sh, trial;

  assign fast_o     = (b_i == '0) | ((a_i == MIN_NEG) & (b_i == '1));
  assign fast_res_o = (b_i == '0) ? '1 : MIN_NEG;
  assign done_o     = fix_q;
  assign quo_o      = neg_q ? -quo_q : quo_q;

  always_comb begin
    run_d  = run_q;
    fix_d  = fix_q;
    neg_d  = neg_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    a_mag  = a_i[XLEN-1] ? -a_i : a_i;
    b_mag  = b_i[XLEN-1] ? -b_i : b_i;
    rem_sh = {rem_q, quo_q[XLEN-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (start_i) begin
      run_d = 1'b1;
      fix_d = 1'b0;
      neg_d = a_i[XLEN-1] ^ b_i[XLEN-1];
      rem_d = '0;
      quo_d = a_mag;
      dvs_d = b_mag;
      cnt_d = CW'(XLEN);
    end else if (run_q) begin
      // Dividend bits shift out of quo_q's top as quotient bits shift into its bottom.
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        run_d = 1'b0;
        fix_d = 1'b1;
      end
    end else if (fix_q) begin
      fix_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      fix_q <= 1'b0;
      neg_q <= 1'b0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      fix_q <= fix_d;
      neg_q <= neg_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: 1-cycle logic/add/shift/compare, iterative MUL (XLEN+1) and DIV (XLEN+2).
// Result held in DONE until out_ready; in_ready only in IDLE, so the pipeline stalls on busy/held results.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_signal,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            busy_o
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, acc_q, acc_d, mca_q, mca_d, mpb_q, mpb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] alu_res, acc_nxt, div_fast_res, div_quo;
  logic [SHW-1:0]  shamt;
  logic            accept, div_start, div_fast, div_done;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy_o    = (state_q == MUL) | (state_q == DIV);
  assign result_o  = result_q;
  assign zero_o    = (result_q == '0);
  assign shamt     = src_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_signal)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SLT:  alu_res[0] = $signed(src_a) < $signed(src_b);
      ALU_SLTU: alu_res[0] = src_a < src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      ALU_OR:   alu_res = src_a | src_b;
      ALU_AND:  alu_res = src_a & src_b;
      default:  alu_res = src_a + src_b;
    endcase
  end

  alu_divider #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .a_i        (src_a),
    .b_i        (src_b),
    .fast_o     (div_fast),
    .fast_res_o (div_fast_res),
    .done_o     (div_done),
    .quo_o      (div_quo)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    acc_d     = acc_q;
    mca_d     = mca_q;
    mpb_d     = mpb_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    acc_nxt   = mpb_q[0] ? acc_q + mca_q : acc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (alu_signal == ALU_MUL) begin
            state_d = MUL;
            acc_d   = '0;
            mca_d   = src_a;
            mpb_d   = src_b;
            cnt_d   = CW'(XLEN);
          end else if (alu_signal == ALU_DIV) begin
            if (div_fast) begin
              result_d = div_fast_res;
              state_d  = DONE;
            end else begin
              div_start = 1'b1;
              state_d   = DIV;
            end
          end else begin
            result_d = alu_res;
            state_d  = DONE;
          end
        end
      end
      MUL: begin
        // Shift-add: multiplicand moves left, multiplier bits consumed from the LSB.
        acc_d = acc_nxt;
        mca_d = mca_q << 1;
        mpb_d = mpb_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          result_d = acc_nxt;
          state_d  = DONE;
        end
      end
      DIV: begin
        if (div_done) begin
          result_d = div_quo;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      acc_q    <= '0;
      mca_q    <= '0;
      mpb_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      mca_q    <= mca_d;
      mpb_q    <= mpb_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, randomized ops vs. arithmetic model,
// and hand sequences for backpressure and reset during MUL.
module tb_alu_exec;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_signal = 5'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result_o;
  logic        zero_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_signal (alu_signal),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the op-code rules, plus the documented latencies.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    logic [63:0] prod;
    lat = 1;
    case (op)
      5'd1:  res = a - b;
      5'd2:  res = a << b[4:0];
      5'd3:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  res = (a < b) ? 32'd1 : 32'd0;
      5'd5:  res = a ^ b;
      5'd6:  res = a >> b[4:0];
      5'd7:  res = $signed(a) >>> b[4:0];
      5'd8:  res = a | b;
      5'd9:  res = a & b;
      5'd10: begin prod = {32'd0, a} * {32'd0, b}; res = prod[31:0]; lat = 33; end
      5'd11: begin
        if (b == 32'd0) res = 32'hFFFF_FFFF;
        else if (a == MIN_NEG && b == 32'hFFFF_FFFF) res = MIN_NEG;
        else begin res = $signed(a) / $signed(b); lat = 34; end
      end
      default: res = a + b;
    endcase
  endtask

  // Issue one op from IDLE; optionally stall out_ready for `stall` cycles once the result appears.
  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                       input int stall);
    int lat, busy_cnt;
    bit held;
    check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    out_ready  = (stall == 0);
    in_valid   = 1'b1;
    alu_signal = op;
    src_a      = a;
    src_b      = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a    = $urandom;
    src_b    = $urandom;
    alu_signal = 5'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      busy_cnt += int'(busy_o);
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL %s timeout: no out_valid within %0d cycles", name, lat);
      out_ready = 1'b1;
      return;
    end
    check({name, " result"}, result_o, exp_res);
    check({name, " zero"}, {31'd0, zero_o}, {31'd0, exp_res == 32'd0});
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy cycles"}, busy_cnt, exp_lat - 1);
    held = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (!out_valid || result_o !== exp_res || in_ready) held = 1'b0;
    end
    if (stall > 0) check({name, " held"}, {31'd0, held}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " handshake"}, {31'd0, out_valid}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] er, ra, rb;
    logic [4:0]  rop;
    int el, n;
    vecs[0]  = '{5'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1};
    vecs[1]  = '{5'd1,  32'd5,         32'd5,         32'h0,         1};
    vecs[2]  = '{5'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 1};
    vecs[3]  = '{5'd6,  32'h8000_0000, 32'h24,        32'h0800_0000, 1};
    vecs[4]  = '{5'd3,  32'hFFFF_FFFF, 32'd1,         32'd1,         1};
    vecs[5]  = '{5'd4,  32'hFFFF_FFFF, 32'd1,         32'd0,         1};
    vecs[6]  = '{5'd10, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[7]  = '{5'd11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    vecs[8]  = '{5'd11, 32'd7,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[10] = '{5'd2,  32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{5'd20, 32'd40,        32'd2,         32'd42,        1};

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset zero", {31'd0, zero_o}, 32'd1);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 0);

    // Backpressure: result held, and a held in_valid is only accepted after the out handshake.
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    alu_signal = 5'd0; src_a = 32'd1; src_b = 32'd2;
    @(posedge clk); #1;
    src_a = 32'd10; src_b = 32'd20;
    check("bp first result", result_o, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp held valid", {31'd0, out_valid}, 32'd1);
      check("bp held result", result_o, 32'd3);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp handoff no accept", {31'd0, out_valid}, 32'd0);
    check("bp handoff in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp second valid", {31'd0, out_valid}, 32'd1);
    check("bp second result", result_o, 32'd30);
    @(posedge clk); #1;

    // Reset during MUL iteration 10: op is abandoned, nothing presented for it.
    in_valid = 1'b1; alu_signal = 5'd10; src_a = 32'd1234; src_b = 32'd5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mul busy before rst", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", result_o, 32'd0);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n += int'(out_valid);
    end
    check("abandoned op silent", n, 0);
    do_op("post-rst add", 5'd0, 32'd2, 32'd3, 32'd5, 1, 0);

    for (int i = 0; i < 80; i++) begin
      n = $urandom_range(0, 15);
      rop = (n < 12) ? 5'(n) : 5'($urandom_range(12, 31));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: if (rop == 5'd11) rb = 32'd0;
        2: if (rop == 5'd11) begin ra = MIN_NEG; rb = 32'hFFFF_FFFF; end
        3: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      model(rop, ra, rb, er, el);
      do_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, er, el, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
endmodule
